// File: rtl/signature_dump_dma.sv
// signature_dump_dma
//
// Extracts the compliance test signature from RAM at the end of a test.
// Software programs BEGIN/END (END exclusive) through the device port and
// writes CTRL.start; the block then reads the region one word at a time
// through its host port. Each word goes out on a valid/ready stream together
// with its address. done_o rises when the dump is over.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dev_*                  register slave: req always accepted, response
//                          (rvalid/rdata/err) exactly one cycle later
//   host_*                 read-only bus master, one outstanding read
//   sig_valid_o/ready_i    signature word stream, sig_addr_o/sig_data_o payload
//   done_o                 dump complete, sticky until reset
//   dump_err_o             host error or range clamp, sticky until reset
//
// Register map (dev_addr_i[3:2]; dev_addr_i[9:4] must be zero):
//   0x0 CTRL   W   bit0 = start (reads as 0)
//   0x4 BEGIN  RW  bits [1:0] forced to 0
//   0x8 END    RW  bits [1:0] forced to 0, exclusive
//   0xC STATUS RO  bit0 busy, bit1 done, bit2 err, [31:16] words emitted

module signature_dump_dma #(
    parameter int unsigned MaxWords = 16384
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,

    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,

    output logic        sig_valid_o,
    input  logic        sig_ready_i,
    output logic [31:0] sig_addr_o,
    output logic [31:0] sig_data_o,

    output logic        done_o,
    output logic        dump_err_o
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDone} state_e;

    localparam logic [31:0] MaxWordsW = 32'(MaxWords);

    state_e      state_q, state_d;
    logic [31:0] begin_q, begin_d;
    logic [31:0] end_q, end_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] emitted_q, emitted_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        dev_rvalid_q;
    logic [31:0] dev_rdata_q, dev_rdata_d;
    logic        dev_err_q, dev_err_d;

    logic [1:0]  dev_off;
    logic        wr_ok;
    logic        start;
    logic        busy;
    logic [15:0] emitted_sat;
    logic [31:0] status_word;
    logic [31:0] span_words;
    logic [31:0] emitted_inc;

    // Byte enables and undecoded address bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{dev_be_i, dev_addr_i[31:10], dev_addr_i[1:0]};

    // ------------------------------------------------------------------
    // Device port decode
    // ------------------------------------------------------------------
    assign dev_off = dev_addr_i[3:2];
    assign busy    = (state_q == StReq) || (state_q == StWait) || (state_q == StOut);

    assign emitted_sat = (emitted_q > 32'h0000_FFFF) ? 16'hFFFF : emitted_q[15:0];
    assign status_word = {emitted_sat, 13'd0, err_q, (state_q == StDone), busy};

    always_comb begin
        dev_err_d   = dev_req_i && ((|dev_addr_i[9:4]) || (dev_we_i && dev_off == 2'd3));
        dev_rdata_d = 32'd0;
        if (dev_req_i && !dev_we_i && !dev_err_d) begin
            unique case (dev_off)
                2'd1:    dev_rdata_d = begin_q;
                2'd2:    dev_rdata_d = end_q;
                2'd3:    dev_rdata_d = status_word;
                default: dev_rdata_d = 32'd0;
            endcase
        end
    end

    // Writes outside IDLE are acknowledged but dropped, so a running dump
    // can never be disturbed. DONE also drops them, which keeps it sticky.
    assign wr_ok = dev_req_i && dev_we_i && !dev_err_d && (state_q == StIdle);
    assign start = wr_ok && (dev_off == 2'd0) && dev_wdata_i[0];

    always_comb begin
        begin_d = begin_q;
        end_d   = end_q;
        if (wr_ok && dev_off == 2'd1) begin_d = {dev_wdata_i[31:2], 2'b00};
        if (wr_ok && dev_off == 2'd2) end_d   = {dev_wdata_i[31:2], 2'b00};
    end

    // ------------------------------------------------------------------
    // Dump FSM
    // ------------------------------------------------------------------
    // Only meaningful when END > BEGIN, so the subtraction never wraps.
    assign span_words  = (end_q - begin_q) >> 2;
    assign emitted_inc = emitted_q + 32'd1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        emitted_d = emitted_q;
        data_d    = data_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (end_q <= begin_q) begin
                        state_d = StDone;
                    end else begin
                        if (span_words > MaxWordsW) begin
                            count_d = MaxWordsW;
                            err_d   = 1'b1;
                        end else begin
                            count_d = span_words;
                        end
                        ptr_d     = begin_q;
                        emitted_d = 32'd0;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                if (host_gnt_i) state_d = StWait;
            end
            StWait: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        data_d  = host_rdata_i;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (sig_ready_i) begin
                    ptr_d     = ptr_q + 32'd4;
                    emitted_d = emitted_inc;
                    state_d   = (emitted_inc == count_q) ? StDone : StReq;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            begin_q      <= 32'd0;
            end_q        <= 32'd0;
            ptr_q        <= 32'd0;
            count_q      <= 32'd0;
            emitted_q    <= 32'd0;
            data_q       <= 32'd0;
            err_q        <= 1'b0;
            dev_rvalid_q <= 1'b0;
            dev_rdata_q  <= 32'd0;
            dev_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            begin_q      <= begin_d;
            end_q        <= end_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            emitted_q    <= emitted_d;
            data_q       <= data_d;
            err_q        <= err_d;
            dev_rvalid_q <= dev_req_i;
            dev_rdata_q  <= dev_rdata_d;
            dev_err_q    <= dev_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state
    // ------------------------------------------------------------------
    assign dev_rvalid_o = dev_rvalid_q;
    assign dev_rdata_o  = dev_rdata_q;
    assign dev_err_o    = dev_err_q;

    assign host_req_o   = (state_q == StReq);
    assign host_addr_o  = ptr_q;

    assign sig_valid_o  = (state_q == StOut);
    assign sig_addr_o   = ptr_q;
    assign sig_data_o   = data_q;

    assign done_o       = (state_q == StDone);
    assign dump_err_o   = err_q;

endmodule
